// File: rtl/prng_xoroshiro128p_jump.sv
// Jump / long-jump engine for a xoroshiro128+ (24,16,37) generator: freezes the generator,
// walks 128 shadow steps accumulating the polynomial terms, then reseeds it with the result.
module prng_xoroshiro128p_jump (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cg,
    input  logic        i_seedValid,
    input  logic [63:0] i_seedS0,
    input  logic [63:0] i_seedS1,
    input  logic        i_start,
    input  logic        i_long,
    input  logic [63:0] i_s0,
    input  logic [63:0] i_s1,
    output logic        o_prngCg,
    output logic        o_seedValid,
    output logic [63:0] o_seedS0,
    output logic [63:0] o_seedS1,
    output logic        o_busy,
    output logic        o_done
);

    // Word1 sits in the upper half so that idx indexes the polynomial bit directly.
    localparam logic [127:0] JUMP      = {64'h170865df4b3201fc, 64'hdf900294d8f554a5};
    localparam logic [127:0] LONG_JUMP = {64'hdddf9b1090aa7ac1, 64'hd2a98b26625eee7b};

    typedef enum logic [1:0] {IDLE, RUN, LOAD} state_t;

    state_t      state, state_nxt;
    logic [6:0]  idx;
    logic        sel;
    logic [63:0] t0, t1, a0, a1;
    logic [63:0] x, t0_step, t1_step;
    logic        k;

    always_comb begin
        x       = t0 ^ t1;
        t0_step = {t0[39:0], t0[63:40]} ^ x ^ (x << 16);
        t1_step = {x[26:0], x[63:27]};
        k       = sel ? LONG_JUMP[idx] : JUMP[idx];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        o_prngCg    = i_cg;
        o_seedValid = i_seedValid;
        o_seedS0    = i_seedS0;
        o_seedS1    = i_seedS1;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) state_nxt = RUN;
            end
            RUN: begin
                o_prngCg    = 1'b0;
                o_seedValid = 1'b0;
                o_seedS0    = a0;
                o_seedS1    = a1;
                o_busy      = 1'b1;
                if (idx == 7'd127) state_nxt = LOAD;
            end
            LOAD: begin
                o_prngCg    = 1'b1;
                o_seedValid = 1'b1;
                o_seedS0    = a0;
                o_seedS1    = a1;
                o_busy      = 1'b1;
                o_done      = 1'b1;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            idx <= '0;
            sel <= 1'b0;
            t0  <= '0;
            t1  <= '0;
            a0  <= '0;
            a1  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        // A seed arriving with start is the state we jump from.
                        t0  <= i_seedValid ? i_seedS0 : i_s0;
                        t1  <= i_seedValid ? i_seedS1 : i_s1;
                        a0  <= '0;
                        a1  <= '0;
                        idx <= '0;
                        sel <= i_long;
                    end
                end
                RUN: begin
                    if (k) begin
                        a0 <= a0 ^ t0;
                        a1 <= a1 ^ t1;
                    end
                    t0  <= t0_step;
                    t1  <= t1_step;
                    idx <= idx + 7'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prng_xoroshiro128p_jump.sv
// Bench for the jump engine: a behavioural xoroshiro128+ generator closes the loop and a
// reference jump()/long_jump() supplies the expected reseed values.
module tb_prng_xoroshiro128p_jump;

    logic        i_clk = 1'b0;
    logic        i_rst, i_cg, i_seedValid, i_start, i_long;
    logic [63:0] i_seedS0, i_seedS1;
    logic        o_prngCg, o_seedValid, o_busy, o_done;
    logic [63:0] o_seedS0, o_seedS1;
    logic [63:0] gen_s0 = '0, gen_s1 = '0;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    prng_xoroshiro128p_jump dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_cg(i_cg), .i_seedValid(i_seedValid),
        .i_seedS0(i_seedS0), .i_seedS1(i_seedS1), .i_start(i_start), .i_long(i_long),
        .i_s0(gen_s0), .i_s1(gen_s1), .o_prngCg(o_prngCg), .o_seedValid(o_seedValid),
        .o_seedS0(o_seedS0), .o_seedS1(o_seedS1), .o_busy(o_busy), .o_done(o_done)
    );

    function automatic logic [63:0] rotl(input logic [63:0] v, input int r);
        return (v << r) | (v >> (64 - r));
    endfunction

    function automatic logic [127:0] gen_next(input logic [63:0] s0, input logic [63:0] s1);
        logic [63:0] y;
        y = s1 ^ s0;
        return {rotl(y, 37), rotl(s0, 24) ^ y ^ (y << 16)};
    endfunction

    // Reference jump: {a1, a0} after walking both constant words LSB first.
    function automatic logic [127:0] jump_ref(input logic [63:0] s0, input logic [63:0] s1,
                                              input logic lng);
        logic [63:0]  w [2];
        logic [63:0]  c0, c1, r0, r1;
        logic [127:0] nx;
        c0 = s0; c1 = s1; r0 = '0; r1 = '0;
        w[0] = lng ? 64'hd2a98b26625eee7b : 64'hdf900294d8f554a5;
        w[1] = lng ? 64'hdddf9b1090aa7ac1 : 64'h170865df4b3201fc;
        for (int wi = 0; wi < 2; wi++)
            for (int b = 0; b < 64; b++) begin
                if (w[wi][b]) begin
                    r0 ^= c0;
                    r1 ^= c1;
                end
                nx = gen_next(c0, c1);
                c0 = nx[63:0];
                c1 = nx[127:64];
            end
        return {r1, r0};
    endfunction

    // Generator stand-in: seed load has priority over stepping.
    always @(posedge i_clk) begin
        if (o_seedValid) begin
            gen_s0 <= o_seedS0;
            gen_s1 <= o_seedS1;
        end else if (o_prngCg) begin
            gen_s0 <= gen_next(gen_s0, gen_s1)[63:0];
            gen_s1 <= gen_next(gen_s0, gen_s1)[127:64];
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [63:0] s0, s1;
        logic        lng;
        logic        via_seed;  // seed presented in the start cycle
        logic        noise;     // start/seed pulses while busy
        logic [63:0] e0, e1;
    } vec_t;

    vec_t vecs[7];

    task automatic run_vec(input int n, input vec_t v);
        int bad_run;
        if (v.via_seed) begin
            i_seedValid = 1'b1; i_seedS0 = 64'hdeadbeefcafef00d; i_seedS1 = 64'h0123456789abcdef;
            tick();
            i_seedS0 = v.s0; i_seedS1 = v.s1;
        end else begin
            i_seedValid = 1'b1; i_seedS0 = v.s0; i_seedS1 = v.s1;
            tick();
            i_seedValid = 1'b0;
            i_seedS0 = 64'h5555aaaa5555aaaa; i_seedS1 = 64'h3333cccc3333cccc;
        end
        i_start = 1'b1; i_long = v.lng;
        tick();
        i_start = 1'b0; i_seedValid = 1'b0; i_long = ~v.lng; i_cg = 1'b1;
        i_seedS0 = 64'hffffffffffffffff; i_seedS1 = 64'h8000000000000001;
        bad_run = 0;
        for (int c = 1; c <= 128; c++) begin
            if (v.noise) begin
                i_start     = (c == 10 || c == 60);
                i_seedValid = (c == 10 || c == 60);
            end
            if (o_busy !== 1'b1 || o_prngCg !== 1'b0 || o_seedValid !== 1'b0 || o_done !== 1'b0)
                bad_run++;
            tick();
        end
        chk($sformatf("v%0d run_bad_cycles", n), 64'(bad_run), 64'd0);
        i_start = v.noise; i_seedValid = v.noise; i_cg = 1'b0;
        chk($sformatf("v%0d load_done", n), 64'(o_done), 64'd1);
        chk($sformatf("v%0d load_ctrl", n), {61'd0, o_seedValid, o_prngCg, o_busy}, 64'd7);
        chk($sformatf("v%0d load_s0", n), o_seedS0, v.e0);
        chk($sformatf("v%0d load_s1", n), o_seedS1, v.e1);
        tick();
        i_start = 1'b0; i_seedValid = 1'b0;
        chk($sformatf("v%0d idle_after", n), {62'd0, o_busy, o_done}, 64'd0);
        chk($sformatf("v%0d gen_s0", n), gen_s0, v.e0);
        chk($sformatf("v%0d gen_s1", n), gen_s1, v.e1);
        chk($sformatf("v%0d gen_result", n), gen_s0 + gen_s1, v.e0 + v.e1);
    endtask

    initial begin
        logic [127:0] r;
        vecs[0] = '{64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0};
        vecs[1] = '{64'd1, 64'd2, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0};
        vecs[2] = '{64'd1, 64'd2, 1'b1, 1'b0, 1'b0, 64'd0, 64'd0};
        vecs[3] = '{64'd1, 64'd2, 1'b0, 1'b1, 1'b0, 64'd0, 64'd0};
        vecs[4] = '{64'd1, 64'd2, 1'b1, 1'b1, 1'b0, 64'd0, 64'd0};
        vecs[5] = '{64'h0123456789abcdef, 64'hfedcba9876543210, 1'b0, 1'b0, 1'b1, 64'd0, 64'd0};
        vecs[6] = '{64'h8000000000000000, 64'h0000000000000001, 1'b1, 1'b0, 1'b0, 64'd0, 64'd0};
        for (int i = 1; i < 7; i++) begin
            r = jump_ref(vecs[i].s0, vecs[i].s1, vecs[i].lng);
            vecs[i].e0 = r[63:0];
            vecs[i].e1 = r[127:64];
        end

        i_rst = 1'b1; i_cg = 1'b0; i_seedValid = 1'b0; i_seedS0 = '0; i_seedS1 = '0;
        i_start = 1'b0; i_long = 1'b0;
        tick(); tick();
        i_rst = 1'b0;
        i_cg = 1'b1; i_seedValid = 1'b1; i_seedS0 = 64'd5; i_seedS1 = 64'd7;
        #1;
        chk("rst_busy_done", {62'd0, o_busy, o_done}, 64'd0);
        chk("pass_cg", 64'(o_prngCg), 64'd1);
        chk("pass_seed_valid", 64'(o_seedValid), 64'd1);
        chk("pass_s0", o_seedS0, 64'd5);
        chk("pass_s1", o_seedS1, 64'd7);
        i_cg = 1'b0;
        #1;
        chk("pass_cg_low", 64'(o_prngCg), 64'd0);
        i_seedValid = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Reset lands in RUN: no seed load, generator stays frozen until i_cg resumes.
        i_seedValid = 1'b1; i_seedS0 = 64'd1; i_seedS1 = 64'd2;
        tick();
        i_seedValid = 1'b0; i_start = 1'b1; i_long = 1'b0;
        tick();
        i_start = 1'b0;
        begin
            int sv_seen = 0;
            int moved = 0;
            for (int c = 1; c <= 53; c++) begin
                i_rst = (c == 50);
                if (o_seedValid) sv_seen++;
                if (gen_s0 !== 64'd1 || gen_s1 !== 64'd2) moved++;
                if (c == 51) chk("rst_mid_busy", 64'(o_busy), 64'd0);
                tick();
            end
            chk("rst_mid_no_seed", 64'(sv_seen), 64'd0);
            chk("rst_mid_gen_hold", 64'(moved), 64'd0);
        end
        i_cg = 1'b1;
        tick();
        i_cg = 1'b0;
        r = gen_next(64'd1, 64'd2);
        chk("resume_s0", gen_s0, r[63:0]);
        chk("resume_s1", gen_s1, r[127:64]);
        chk("resume_s0_hand", gen_s0, 64'h0000000001030003);
        chk("resume_s1_hand", gen_s1, 64'h0000006000000000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
